// File: rtl/des_key_scheduler.sv
// DES key schedule sequencer: applies PC-1 to a loaded key, then streams PC-2 round keys
// in encrypt (K1..K16) or decrypt (K16..K1) order by rotating the C/D halves in place.
module des_key_scheduler #(
    parameter int unsigned ROUNDS      = 16,
    parameter logic [15:0] SHIFT2_MASK = 16'h7EFC
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [63:0] KEY_IN,
    input  logic        MODE,
    input  logic        KEY_VALID,
    output logic        KEY_READY,
    input  logic        ABORT,
    output logic [47:0] RK_OUT,
    output logic [3:0]  RK_IDX,
    output logic        RK_VALID,
    input  logic        RK_READY,
    output logic        BUSY,
    output logic        DONE
);

    // DES tables use 1-based bit numbers with bit 1 as the MSB.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {StIdle, StRun} state_t;

    function automatic logic [55:0] pc1_perm(input logic [63:0] key);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = key[6'(64 - PC1_TAB[i])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state_q;
    logic        mode_q;
    logic [27:0] c_q, d_q;
    logic [3:0]  rk_idx_q;
    logic        rk_valid_q, busy_q, done_q;

    logic [55:0] key_cd;
    logic [3:0]  nxt_idx, dec_idx;
    logic        last_idx;
    logic [27:0] c_nxt, d_nxt;
    logic        unused_parity;

    assign key_cd   = pc1_perm(KEY_IN);
    assign last_idx = (rk_idx_q == 4'(ROUNDS - 1));
    // Parity bits are dropped by PC-1.
    assign unused_parity = ^{KEY_IN[56], KEY_IN[48], KEY_IN[40], KEY_IN[32],
                             KEY_IN[24], KEY_IN[16], KEY_IN[8],  KEY_IN[0]};

    // Decrypt walks the encrypt schedule backwards: undo the shift of round ROUNDS-j.
    always_comb begin
        nxt_idx = rk_idx_q + 4'd1;
        dec_idx = 4'(ROUNDS) - nxt_idx;
        if (mode_q) begin
            c_nxt = rotr(c_q, SHIFT2_MASK[dec_idx]);
            d_nxt = rotr(d_q, SHIFT2_MASK[dec_idx]);
        end else begin
            c_nxt = rotl(c_q, SHIFT2_MASK[nxt_idx]);
            d_nxt = rotl(d_q, SHIFT2_MASK[nxt_idx]);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            c_q        <= '0;
            d_q        <= '0;
            rk_idx_q   <= '0;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (KEY_VALID) begin
                        mode_q     <= MODE;
                        rk_idx_q   <= '0;
                        rk_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= StRun;
                        if (MODE) begin
                            c_q <= key_cd[55:28];
                            d_q <= key_cd[27:0];
                        end else begin
                            c_q <= rotl(key_cd[55:28], SHIFT2_MASK[0]);
                            d_q <= rotl(key_cd[27:0], SHIFT2_MASK[0]);
                        end
                    end
                end
                StRun: begin
                    if (ABORT) begin
                        state_q    <= StIdle;
                        rk_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (RK_READY) begin
                        if (last_idx) begin
                            state_q    <= StIdle;
                            rk_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            rk_idx_q <= nxt_idx;
                            c_q      <= c_nxt;
                            d_q      <= d_nxt;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign KEY_READY = (state_q == StIdle);
    assign RK_OUT    = pc2_perm({c_q, d_q});
    assign RK_IDX    = rk_idx_q;
    assign RK_VALID  = rk_valid_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Scoreboard bench for des_key_scheduler: a cumulative-shift DES key model feeds an expected
// queue; a negedge monitor pops and compares on every round-key handshake.
module tb_des_key_scheduler;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [63:0] KEY_IN = '0;
    logic        MODE = 1'b0;
    logic        KEY_VALID = 1'b0;
    logic        KEY_READY;
    logic        ABORT = 1'b0;
    logic [47:0] RK_OUT;
    logic [3:0]  RK_IDX;
    logic        RK_VALID;
    logic        RK_READY = 1'b0;
    logic        BUSY;
    logic        DONE;

    des_key_scheduler dut (
        .CLK       (CLK),
        .RST       (RST),
        .KEY_IN    (KEY_IN),
        .MODE      (MODE),
        .KEY_VALID (KEY_VALID),
        .KEY_READY (KEY_READY),
        .ABORT     (ABORT),
        .RK_OUT    (RK_OUT),
        .RK_IDX    (RK_IDX),
        .RK_VALID  (RK_VALID),
        .RK_READY  (RK_READY),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [3:0]  exp_idx [$];
    logic [47:0] exp_rk  [$];
    logic [47:0] got   [16];
    logic [47:0] got_a [16];

    localparam int T_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int T_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Round key K(k), k = 1..16: rotate the PC-1 halves by the total shift up to round k.
    function automatic logic [47:0] model_key(input logic [63:0] key, input int k);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] rk;
        int total;
        for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - T_PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        total = 0;
        for (int r = 0; r < k; r++) total += SHIFTS[r];
        for (int s = 0; s < total % 28; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) rk[47 - i] = cd[56 - T_PC2[i]];
        return rk;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] key, input bit mode);
        for (int i = 0; i < 16; i++) begin
            exp_idx.push_back(4'(i));
            exp_rk.push_back(model_key(key, mode ? 16 - i : i + 1));
        end
    endtask

    task automatic flush_exp();
        exp_idx.delete();
        exp_rk.delete();
    endtask

    // Monitor: pops one expectation per accepted round key; checks stability under stall.
    initial begin
        bit          prev_stall;
        logic [47:0] prev_out;
        logic [3:0]  prev_idx;
        prev_stall = 1'b0;
        prev_out   = '0;
        prev_idx   = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && RK_VALID) begin
                    check("stall_rk_out", 64'(RK_OUT), 64'(prev_out));
                    check("stall_rk_idx", 64'(RK_IDX), 64'(prev_idx));
                end
                if (RK_VALID && RK_READY && !ABORT) begin
                    got[RK_IDX] = RK_OUT;
                    if (exp_idx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rk: got idx %0d key %h expected none",
                                 RK_IDX, RK_OUT);
                    end else begin
                        check("sb_rk_idx", 64'(RK_IDX), 64'(exp_idx.pop_front()));
                        check("sb_rk_out", 64'(RK_OUT), 64'(exp_rk.pop_front()));
                    end
                end
                prev_stall = RK_VALID && !RK_READY && !ABORT;
                prev_out   = RK_OUT;
                prev_idx   = RK_IDX;
            end
        end
    end

    task automatic set_ready(input int pct);
        RK_READY = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
    endtask

    task automatic load(input logic [63:0] key, input bit mode, input int pct);
        int w;
        push_exp(key, mode);
        @(posedge CLK); #1;
        w = 0;
        while (!KEY_READY && w < 100) begin
            @(posedge CLK); #1;
            w++;
        end
        KEY_IN    = key;
        MODE      = mode;
        KEY_VALID = 1'b1;
        set_ready(pct);
        @(posedge CLK); #1;
        KEY_VALID = 1'b0;
        // Disturb MODE/KEY_IN mid-run: only the latched values may matter.
        MODE   = 1'($urandom);
        KEY_IN = {$urandom, $urandom};
        check("load_rk_valid", 64'(RK_VALID), 64'd1);
        check("load_busy", 64'(BUSY), 64'd1);
        check("load_key_ready", 64'(KEY_READY), 64'd0);
        check("load_rk_idx", 64'(RK_IDX), 64'd0);
    endtask

    task automatic drain(input int pct, output int cyc);
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(posedge CLK); #1;
            cyc++;
            if (DONE) seen = 1'b1;
            else set_ready(pct);
        end
        check("done_seen", 64'(seen), 64'd1);
        check("rk_valid_at_done", 64'(RK_VALID), 64'd0);
        check("queue_empty", 64'(exp_idx.size()), 64'd0);
        flush_exp();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int cyc, w, viol;
        logic [63:0] rkey;
        bit rmode;

        // Reset state
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        check("rst_key_ready", 64'(KEY_READY), 64'd1);
        check("rst_rk_valid", 64'(RK_VALID), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_rk_idx", 64'(RK_IDX), 64'd0);

        // Encrypt, full rate
        load(64'h133457799BBCDFF1, 1'b0, 100);
        drain(100, cyc);
        check("enc_done_latency", 64'(cyc), 64'd16);
        check("enc_k1", 64'(got[0]), 64'h1B02EFFC7072);
        check("enc_k2", 64'(got[1]), 64'h79AED9DBC9E5);
        check("enc_k16", 64'(got[15]), 64'hCB3D8B0E17F5);

        // Decrypt, full rate
        load(64'h133457799BBCDFF1, 1'b1, 100);
        drain(100, cyc);
        check("dec_done_latency", 64'(cyc), 64'd16);
        check("dec_idx0", 64'(got[0]), 64'hCB3D8B0E17F5);
        check("dec_idx14", 64'(got[14]), 64'h79AED9DBC9E5);
        check("dec_idx15", 64'(got[15]), 64'h1B02EFFC7072);

        // Backpressure in both modes, then random keys
        load(64'h133457799BBCDFF1, 1'b0, 50);
        drain(50, cyc);
        load(64'h133457799BBCDFF1, 1'b1, 50);
        drain(50, cyc);
        for (int n = 0; n < 4; n++) begin
            rkey  = {$urandom, $urandom};
            rmode = 1'($urandom);
            load(rkey, rmode, 60);
            drain(60, cyc);
        end

        // Asynchronous reset mid-run at RK_IDX=5
        load(64'h133457799BBCDFF1, 1'b0, 100);
        w = 0;
        while (RK_IDX != 4'd5 && w < 50) begin
            @(posedge CLK); #1;
            w++;
        end
        check("reach_idx5", 64'(RK_IDX), 64'd5);
        #1 RST = 1'b1;
        #1;
        check("arst_rk_valid", 64'(RK_VALID), 64'd0);
        check("arst_busy", 64'(BUSY), 64'd0);
        check("arst_rk_idx", 64'(RK_IDX), 64'd0);
        flush_exp();
        @(posedge CLK); #1 RST = 1'b0;
        #1;
        check("arst_key_ready", 64'(KEY_READY), 64'd1);

        // ABORT at RK_IDX=7 with a same-cycle handshake
        load(64'h133457799BBCDFF1, 1'b0, 100);
        w = 0;
        while (RK_IDX != 4'd7 && w < 50) begin
            @(posedge CLK); #1;
            w++;
        end
        check("reach_idx7", 64'(RK_IDX), 64'd7);
        ABORT = 1'b1;
        @(posedge CLK); #1;
        ABORT = 1'b0;
        check("abort_rk_valid", 64'(RK_VALID), 64'd0);
        check("abort_busy", 64'(BUSY), 64'd0);
        check("abort_key_ready", 64'(KEY_READY), 64'd1);
        check("abort_no_done", 64'(DONE), 64'd0);
        flush_exp();
        @(posedge CLK); #1;
        check("abort_no_done_2", 64'(DONE), 64'd0);
        load(64'h0123456789ABCDEF, 1'b0, 100);
        drain(100, cyc);

        // Parity insensitivity and back-to-back with KEY_VALID held through RUN
        push_exp(64'h133457799BBCDFF1, 1'b0);
        push_exp(64'h123456789ABCDEF0, 1'b0);
        @(posedge CLK); #1;
        KEY_IN    = 64'h133457799BBCDFF1;
        MODE      = 1'b0;
        KEY_VALID = 1'b1;
        RK_READY  = 1'b1;
        @(posedge CLK); #1;
        KEY_IN = 64'h123456789ABCDEF0;
        check("b2b_first_valid", 64'(RK_VALID), 64'd1);
        viol = 0;
        cyc  = 0;
        while (!DONE && cyc < 100) begin
            @(posedge CLK); #1;
            cyc++;
            if (!DONE && KEY_READY) viol++;
        end
        check("b2b_done", 64'(DONE), 64'd1);
        check("b2b_no_accept_in_run", 64'(viol), 64'd0);
        check("b2b_valid_at_done", 64'(RK_VALID), 64'd0);
        for (int i = 0; i < 16; i++) got_a[i] = got[i];
        @(posedge CLK); #1;
        KEY_VALID = 1'b0;
        check("b2b_second_valid", 64'(RK_VALID), 64'd1);
        check("b2b_second_idx", 64'(RK_IDX), 64'd0);
        drain(100, cyc);
        viol = 0;
        for (int i = 0; i < 16; i++) if (got_a[i] !== got[i]) viol++;
        check("parity_keys_equal", 64'(viol), 64'd0);

        repeat (2) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
